// File: rtl/uart_io_master.sv
// uart_io_master: hardware initiator for the UART peripheral's memory-mapped IO
// interface. Host bytes are queued in a small TX FIFO. Each byte is sent by polling the
// status word at BASE+0 until bit 0 reads 1, then writing the byte to BASE+0.
// A UART receive interrupt is serviced by reading BASE+4, acknowledging the interrupt
// and presenting the byte to the host. Receive has priority over transmit.
//
// Ports:
//   clock, reset                       rising-edge clock, asynchronous active-high reset
//   tx_data, tx_valid, tx_ready        host byte input (accepted when valid && ready)
//   tx_empty                           FIFO empty and engine idle
//   rx_data, rx_valid                  last received byte, one-cycle update pulse
//   rw_address, read_request, read_data, read_response      IO read channel
//   write_data, write_request, write_response               IO write channel
//   uart_irq, uart_irq_response        UART receive interrupt and acknowledge
module uart_io_master #(
    parameter logic [31:0] UART_BASE_ADDRESS = 32'h8000_0000,
    parameter int unsigned TX_FIFO_DEPTH     = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        tx_empty,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic [31:0] rw_address,
    input  logic [31:0] read_data,
    output logic        read_request,
    input  logic        read_response,
    output logic [7:0]  write_data,
    output logic        write_request,
    input  logic        write_response,
    input  logic        uart_irq,
    output logic        uart_irq_response
);

    localparam int unsigned PtrW = (TX_FIFO_DEPTH > 1) ? $clog2(TX_FIFO_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCount = CntW'(TX_FIFO_DEPTH);
    localparam logic [31:0] StatusAddr = UART_BASE_ADDRESS;
    localparam logic [31:0] RxAddr     = UART_BASE_ADDRESS + 32'd4;

    typedef enum logic [2:0] {StIdle, StPollWait, StWriteWait, StRxWait, StRxAck} state_e;

    // ---------------------------------------------------------------- TX FIFO
    logic [7:0]      fifo_mem [TX_FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            push, pop;

    // Readiness depends only on the registered count, so a full FIFO rejects a push
    // even in a cycle where the engine pops.
    assign tx_ready = (count_q < FullCount);
    assign push     = tx_valid && tx_ready;

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= tx_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // ---------------------------------------------------------------- IO engine
    state_e      state_q, state_d;
    logic [31:0] rw_address_q, rw_address_d;
    logic [7:0]  write_data_q, write_data_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        read_request_q, read_request_d;
    logic        write_request_q, write_request_d;
    logic        irq_response_q, irq_response_d;
    logic        rx_valid_q, rx_valid_d;

    always_comb begin
        state_d         = state_q;
        rw_address_d    = rw_address_q;
        write_data_d    = write_data_q;
        rx_data_d       = rx_data_q;
        read_request_d  = 1'b0;
        write_request_d = 1'b0;
        irq_response_d  = 1'b0;
        rx_valid_d      = 1'b0;
        pop             = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (uart_irq) begin
                    read_request_d = 1'b1;
                    rw_address_d   = RxAddr;
                    state_d        = StRxWait;
                end else if (count_q != '0) begin
                    read_request_d = 1'b1;
                    rw_address_d   = StatusAddr;
                    state_d        = StPollWait;
                end
            end
            StPollWait: begin
                if (read_response) begin
                    if (read_data[0]) begin
                        write_request_d = 1'b1;
                        rw_address_d    = StatusAddr;
                        write_data_d    = fifo_mem[rd_ptr_q];
                        state_d         = StWriteWait;
                    end else begin
                        // Busy: back to idle so a pending interrupt can win arbitration.
                        state_d = StIdle;
                    end
                end
            end
            StWriteWait: begin
                if (write_response) begin
                    pop     = 1'b1;
                    state_d = StIdle;
                end
            end
            StRxWait: begin
                if (read_response) begin
                    rx_data_d      = read_data[7:0];
                    rx_valid_d     = 1'b1;
                    irq_response_d = 1'b1;
                    state_d        = StRxAck;
                end
            end
            // One spare cycle lets the UART drop its interrupt before re-arbitration.
            StRxAck: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= StIdle;
            rw_address_q    <= '0;
            write_data_q    <= '0;
            rx_data_q       <= '0;
            read_request_q  <= 1'b0;
            write_request_q <= 1'b0;
            irq_response_q  <= 1'b0;
            rx_valid_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            rw_address_q    <= rw_address_d;
            write_data_q    <= write_data_d;
            rx_data_q       <= rx_data_d;
            read_request_q  <= read_request_d;
            write_request_q <= write_request_d;
            irq_response_q  <= irq_response_d;
            rx_valid_q      <= rx_valid_d;
        end
    end

    assign rw_address        = rw_address_q;
    assign write_data        = write_data_q;
    assign rx_data           = rx_data_q;
    assign read_request      = read_request_q;
    assign write_request     = write_request_q;
    assign uart_irq_response = irq_response_q;
    assign rx_valid          = rx_valid_q;
    assign tx_empty          = (count_q == '0) && (state_q == StIdle);

    // Upper read-data bits carry nothing this engine needs.
    logic unused_read_data;
    assign unused_read_data = ^read_data[31:8];

endmodule

// File: tb/tb_uart_io_master.sv
module tb_uart_io_master;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int CPB = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_valid = 1'b0;
    wire         tx_ready, tx_empty;
    wire  [7:0]  rx_data;
    wire         rx_valid;
    wire  [31:0] rw_address;
    logic [31:0] read_data;
    wire         read_request;
    logic        read_response;
    wire  [7:0]  write_data;
    wire         write_request;
    logic        write_response;
    wire         uart_irq;
    wire         uart_irq_response;

    always #5 clock = ~clock;

    uart_io_master #(
        .UART_BASE_ADDRESS(BASE),
        .TX_FIFO_DEPTH    (4)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .tx_data          (tx_data),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .tx_empty         (tx_empty),
        .rx_data          (rx_data),
        .rx_valid         (rx_valid),
        .rw_address       (rw_address),
        .read_data        (read_data),
        .read_request     (read_request),
        .read_response    (read_response),
        .write_data       (write_data),
        .write_request    (write_request),
        .write_response   (write_response),
        .uart_irq         (uart_irq),
        .uart_irq_response(uart_irq_response)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------ bench UART model
    int          resp_delay = 1;
    bit          force_busy = 1'b0;
    bit          tx_busy = 1'b0;
    bit          last_status = 1'b0;
    int          wr_count = 0;
    int          busy_polls = 0;
    int          rx_cnt = 0;
    int          rx_rd_cnt = 0;
    logic [7:0]  rx_hold = 8'h00;
    logic [7:0]  tx_byte = 8'h00;
    logic        tx_line = 1'b1;
    logic        rx_line = 1'b1;
    logic [32:0] req_log [$];
    logic [7:0]  tx_out [$];
    event        tx_ev;

    assign uart_irq = (rx_cnt != rx_rd_cnt);

    // IO responder: answers each request after resp_delay cycles and checks that address,
    // data and strobe behave while the response is outstanding.
    bit          r_is_wr, r_abort, st;
    logic [31:0] r_addr;
    logic [7:0]  r_wd;
    initial begin
        read_response  = 1'b0;
        write_response = 1'b0;
        read_data      = 32'hDEAD_BEE0;
        forever begin
            if (!reset && (read_request || write_request)) begin
                r_is_wr = write_request;
                r_addr  = rw_address;
                r_wd    = write_data;
                req_log.push_back({r_is_wr, r_addr});
                r_abort = 1'b0;
                for (int i = 0; i < resp_delay && !r_abort; i++) begin
                    @(posedge clock); #1;
                    if (reset) r_abort = 1'b1;
                    else begin
                        check("hold_addr", rw_address, r_addr);
                        check("single_pulse", {31'b0, read_request | write_request}, 32'd0);
                        if (r_is_wr) check("hold_wdata", {24'b0, write_data}, {24'b0, r_wd});
                    end
                end
                if (!r_abort) begin
                    if (r_is_wr) begin
                        check("write_addr", r_addr, BASE);
                        check("write_after_ready", {31'b0, last_status}, 32'd1);
                        wr_count++;
                        tx_byte = r_wd;
                        ->tx_ev;
                        write_response = 1'b1;
                    end else begin
                        if (r_addr == BASE) begin
                            st          = !tx_busy && !force_busy;
                            read_data   = {31'b0, st};
                            last_status = st;
                            if (!st) busy_polls++;
                        end else begin
                            check("read_addr", r_addr, BASE + 32'd4);
                            check("rx_read_pending", {31'b0, uart_irq}, 32'd1);
                            read_data = {24'b0, rx_hold};
                            rx_rd_cnt++;
                        end
                        read_response = 1'b1;
                    end
                    @(posedge clock); #1;
                    read_response  = 1'b0;
                    write_response = 1'b0;
                    read_data      = 32'hDEAD_BEE0;
                end
            end else begin
                @(posedge clock); #1;
            end
        end
    end

    // Serializer: 8N1 frame on tx_line, busy until the stop bit ends.
    logic [9:0] frame;
    initial begin
        forever begin
            @(tx_ev);
            tx_busy = 1'b1;
            frame = {1'b1, tx_byte, 1'b0};
            for (int b = 0; b < 10; b++) begin
                tx_line = frame[b];
                repeat (CPB) @(posedge clock);
                #1;
            end
            tx_busy = 1'b0;
        end
    end

    // Line decoder for tx_line (mid-bit sampling).
    logic [7:0] tsh;
    initial begin
        forever begin
            @(negedge tx_line);
            repeat (CPB / 2) @(posedge clock);
            for (int b = 0; b < 8; b++) begin
                repeat (CPB) @(posedge clock);
                tsh[b] = tx_line;
            end
            repeat (CPB) @(posedge clock);
            tx_out.push_back(tsh);
        end
    end

    // UART receiver on rx_line; raises the interrupt when a byte is complete.
    logic [7:0] rsh;
    initial begin
        forever begin
            @(negedge rx_line);
            repeat (CPB / 2) @(posedge clock);
            for (int b = 0; b < 8; b++) begin
                repeat (CPB) @(posedge clock);
                rsh[b] = rx_line;
            end
            repeat (CPB) @(posedge clock);
            #1;
            rx_hold = rsh;
            rx_cnt++;
        end
    end

    // Output monitor.
    int         rx_valid_cnt = 0;
    int         irq_resp_cnt = 0;
    int         irq_idx = 0;
    logic [7:0] rx_seen = 8'h00;
    bit         irq_prev = 1'b0;
    initial begin
        forever begin
            @(negedge clock);
            if (rx_valid) begin
                rx_valid_cnt++;
                rx_seen = rx_data;
            end
            if (uart_irq_response) irq_resp_cnt++;
            if (uart_irq && !irq_prev) irq_idx = req_log.size();
            irq_prev = uart_irq;
        end
    end

    // ------------------------------------------------------------ helpers
    task automatic send_rx(input logic [7:0] b);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        @(posedge clock); #1;
        for (int i = 0; i < 10; i++) begin
            rx_line = f[i];
            repeat (CPB) @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_quiet(input string name);
        int n;
        n = 0;
        while (!(tx_empty && !tx_busy && !read_request && !write_request) && n < 2000) begin
            @(posedge clock); #1;
            n++;
        end
        check(name, {31'b0, n < 2000}, 32'd1);
    endtask

    task automatic expect_serial(input string name, input logic [7:0] exp);
        int n;
        logic [7:0] got;
        n = 0;
        while (tx_out.size() == 0 && n < 800) begin
            @(posedge clock); #1;
            n++;
        end
        if (tx_out.size() == 0) check({name, "_timeout"}, 32'd0, 32'd1);
        else begin
            got = tx_out.pop_front();
            check(name, {24'b0, got}, {24'b0, exp});
        end
    endtask

    // Requests logged since the interrupt rose: BASE+0 ones seen before the BASE+4 read.
    task automatic scan_after(input int idx, output int polls, output bit found);
        polls = 0;
        found = 1'b0;
        for (int i = idx; i < req_log.size(); i++) begin
            if (!found) begin
                if (req_log[i][31:0] == BASE + 32'd4) found = 1'b1;
                else if (req_log[i][31:0] == BASE) polls++;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rw_address"}, rw_address, 32'd0);
        check({tag, "_write_data"}, {24'b0, write_data}, 32'd0);
        check({tag, "_read_request"}, {31'b0, read_request}, 32'd0);
        check({tag, "_write_request"}, {31'b0, write_request}, 32'd0);
        check({tag, "_irq_response"}, {31'b0, uart_irq_response}, 32'd0);
        check({tag, "_rx_data"}, {24'b0, rx_data}, 32'd0);
        check({tag, "_rx_valid"}, {31'b0, rx_valid}, 32'd0);
        check({tag, "_tx_ready"}, {31'b0, tx_ready}, 32'd1);
        check({tag, "_tx_empty"}, {31'b0, tx_empty}, 32'd1);
    endtask

    // ------------------------------------------------------------ vectors
    typedef struct {
        logic [7:0] data;
        int         delay;     // responder latency in cycles
        int         rd_k;      // cycle after push edge where read_request is seen
        int         wr_k;      // cycle after push edge where write_request is seen
        int         empty_k;   // cycle after push edge where tx_empty returns
    } vec_t;
    vec_t vecs [4];

    int         rk, wk, ek, n, first_stall, polls, saved, bp0, wc0, rv0, ir0;
    bit         found, rdy;

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'h55, 1, 1, 3, 5};
        vecs[1] = '{8'hAA, 1, 1, 3, 5};
        vecs[2] = '{8'h00, 2, 1, 4, 7};
        vecs[3] = '{8'h3C, 5, 1, 7, 13};

        // Reset values.
        repeat (2) @(posedge clock);
        #1;
        check_reset_outputs("reset");
        @(negedge clock);
        reset = 1'b0;

        // Single-byte transfers with latency measured from the push edge.
        for (int v = 0; v < 4; v++) begin
            resp_delay = vecs[v].delay;
            wait_quiet("quiet_before_vec");
            @(posedge clock); #1;
            tx_data  = vecs[v].data;
            tx_valid = 1'b1;
            @(posedge clock); #1;
            tx_valid = 1'b0;
            check("empty_after_push", {31'b0, tx_empty}, 32'd0);
            rk = -1; wk = -1; ek = -1;
            for (int k = 1; k <= 40; k++) begin
                @(posedge clock); #1;
                if (read_request && rk < 0) begin
                    rk = k;
                    check("poll_addr", rw_address, BASE);
                end
                if (write_request && wk < 0) begin
                    wk = k;
                    check("wdata", {24'b0, write_data}, {24'b0, vecs[v].data});
                end
                if (wk >= 0 && ek < 0 && tx_empty) ek = k;
            end
            check("read_cycle", rk, vecs[v].rd_k);
            check("write_cycle", wk, vecs[v].wr_k);
            check("empty_cycle", ek, vecs[v].empty_k);
            expect_serial("serial_vec", vecs[v].data);
        end

        // Burst of six into a four-deep FIFO.
        resp_delay = 1;
        wait_quiet("quiet_before_burst");
        bp0 = busy_polls;
        wc0 = wr_count;
        n = 0;
        first_stall = -1;
        @(posedge clock); #1;
        tx_data  = 8'h01;
        tx_valid = 1'b1;
        for (int c = 0; c < 4000 && n < 6; c++) begin
            @(negedge clock);
            rdy = tx_ready;
            if (!rdy && first_stall < 0) first_stall = n;
            @(posedge clock); #1;
            if (rdy) begin
                n++;
                tx_data = 8'(n + 1);
            end
        end
        tx_valid = 1'b0;
        check("burst_accepted", n, 6);
        check("burst_first_stall", first_stall, 4);
        for (int i = 1; i <= 6; i++) expect_serial("serial_burst", 8'(i));
        wait_quiet("quiet_after_burst");
        check("burst_writes", wr_count - wc0, 6);
        check("burst_busy_polled", {31'b0, busy_polls > bp0}, 32'd1);

        // Receive with an empty FIFO.
        rv0 = rx_valid_cnt;
        ir0 = irq_resp_cnt;
        send_rx(8'hA3);
        repeat (20) @(posedge clock);
        #1;
        scan_after(irq_idx, polls, found);
        check("rx_read_issued", {31'b0, found}, 32'd1);
        check("rx_valid_pulses", rx_valid_cnt - rv0, 1);
        check("rx_irq_resp_pulses", irq_resp_cnt - ir0, 1);
        check("rx_seen", {24'b0, rx_seen}, 32'h0000_00A3);
        check("rx_data_held", {24'b0, rx_data}, 32'h0000_00A3);
        check("rx_irq_cleared", {31'b0, uart_irq}, 32'd0);

        // Interrupt arriving while queued bytes are stuck behind a busy UART.
        force_busy = 1'b1;
        @(posedge clock); #1;
        tx_data  = 8'h11;
        tx_valid = 1'b1;
        @(posedge clock); #1;
        tx_data  = 8'h22;
        @(posedge clock); #1;
        tx_valid = 1'b0;
        repeat (20) @(posedge clock);
        rv0 = rx_valid_cnt;
        send_rx(8'h5A);
        repeat (20) @(posedge clock);
        #1;
        scan_after(irq_idx, polls, found);
        check("prio_rx_read", {31'b0, found}, 32'd1);
        check("prio_polls_before_rx", polls, 0);
        check("prio_rx_valid", rx_valid_cnt - rv0, 1);
        check("prio_rx_data", {24'b0, rx_data}, 32'h0000_005A);
        force_busy = 1'b0;
        expect_serial("serial_prio", 8'h11);
        expect_serial("serial_prio", 8'h22);

        // Asynchronous reset while a write is outstanding.
        wait_quiet("quiet_before_reset");
        resp_delay = 20;
        @(posedge clock); #1;
        tx_valid = 1'b1;
        tx_data  = 8'hB1;
        @(posedge clock); #1;
        tx_data  = 8'hB2;
        @(posedge clock); #1;
        tx_data  = 8'hB3;
        @(posedge clock); #1;
        tx_valid = 1'b0;
        n = 0;
        while (!write_request && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        check("midwrite_reached", {31'b0, write_request}, 32'd1);
        repeat (3) @(posedge clock);
        @(negedge clock);
        #2;
        check("midwrite_wdata", {24'b0, write_data}, 32'h0000_00B1);
        reset = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        saved = req_log.size();
        repeat (40) @(posedge clock);
        #1;
        check("no_req_after_reset", req_log.size(), saved);
        check("empty_after_reset", {31'b0, tx_empty}, 32'd1);
        check("no_serial_after_reset", tx_out.size(), 0);

        // Engine resumes on a fresh push.
        resp_delay = 1;
        @(posedge clock); #1;
        tx_data  = 8'hC7;
        tx_valid = 1'b1;
        @(posedge clock); #1;
        tx_valid = 1'b0;
        expect_serial("serial_after_reset", 8'hC7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_io_master.md
Name: uart_io_master

Overview:
- Hardware initiator for the UART peripheral's memory-mapped IO interface, so host logic can exchange bytes without a CPU.
- Buffers outgoing bytes in a small TX FIFO.
- Before each write, polls the UART status word at BASE+0, then writes the byte to BASE+0.
- Services the UART receive interrupt: reads BASE+4, pulses uart_irq_response, and presents the byte to the host.
- Sits between the UART peripheral and a byte-stream client, such as a boot loader or debug bridge.

Parameters:
- UART_BASE_ADDRESS, 32'h80000000, UART base address. Status/TX register at +0, RX data at +4.
- TX_FIFO_DEPTH, 4, TX FIFO entries. Power of two, 2 to 16.

Ports:
- clock  in  1  system clock; everything on the rising edge
- reset  in  1  asynchronous, active-high reset
- tx_data  in  8  byte to transmit
- tx_valid  in  1  host offers tx_data
- tx_ready  out  1  FIFO count < TX_FIFO_DEPTH; a byte is accepted when tx_valid && tx_ready
- tx_empty  out  1  FIFO empty and FSM in IDLE
- rx_data  out  8  last received byte; held until the next reception
- rx_valid  out  1  one-cycle pulse when rx_data updates; no backpressure
- rw_address  out  32  IO address
- read_data  in  32  IO read data; valid when read_response is high
- read_request  out  1  IO read strobe
- read_response  in  1  IO read completion
- write_data  out  8  IO write data
- write_request  out  1  IO write strobe
- write_response  in  1  IO write completion
- uart_irq  in  1  UART receive interrupt (level)
- uart_irq_response  out  1  interrupt acknowledge

Behaviour:
- Reset values: all outputs registered and cleared on reset:
  - rw_address=0, write_data=0, requests=0, uart_irq_response=0, rx_data=0, rx_valid=0.
  - FIFO empty, so tx_ready=1 and tx_empty=1. FSM=IDLE.
- Reset mid-operation: the FIFO is flushed and any in-flight request is abandoned. No response is awaited after reset.
- IO handshake:
  - Each request is a registered single-cycle pulse.
  - rw_address (and write_data for writes) is set in the same cycle as the request and held until the matching response.
  - The FSM waits indefinitely for the response. Only one transaction is outstanding at a time.
- FSM states:
  - IDLE:
    - If uart_irq=1, read rw_address=BASE+4 and go to RX_WAIT. RX has priority over TX.
    - Else if the FIFO is non-empty, read rw_address=BASE+0 and go to POLL_WAIT.
  - POLL_WAIT: on read_response:
    - If read_data[0]=1, pulse write_request with rw_address=BASE+0 and write_data=FIFO head, then go to WRITE_WAIT.
    - Otherwise go to IDLE, which re-arbitrates so a pending irq can preempt.
  - WRITE_WAIT: on write_response, pop the FIFO and go to IDLE.
  - RX_WAIT: on read_response:
    - rx_data <= read_data[7:0] and rx_valid pulses one cycle.
    - uart_irq_response pulses one cycle.
    - Go to RX_ACK.
  - RX_ACK: go to IDLE after one cycle, which guarantees uart_irq has dropped before re-arbitration.
- Latency: with a free UART, a byte pushed on edge E0 into an empty FIFO while IDLE produces:
  - read_request high in the cycle after E1;
  - write_request high in the cycle after E3;
  - FIFO pop on E5.
- FIFO rules:
  - Circular pointers wrap modulo DEPTH.
  - When full, tx_ready=0 even if a pop occurs in the same cycle; the push is rejected.
  - Push and pop in the same cycle when not full leaves the count unchanged.
  - A push while empty and IDLE is visible to the FSM on the next cycle.
- TX ordering: bytes are sent in push order, with no loss and no duplication. Polling repeats until the status reads 1.

Test Plan:
- Single TX:
  - Stimulus: bench UART responder with CYCLES_PER_BAUD=16; push 8'h55 after reset.
  - Required: read at 32'h80000000, then write of 8'h55 at 32'h80000000 with write_request high in the third cycle after the push edge; the serial line carries 0x55; tx_empty returns to 1.
- Burst/full:
  - Stimulus: push 8'h01..8'h06 back-to-back with DEPTH=4.
  - Required: tx_ready drops after 4 held entries and stalls until a pop; the UART emits 01..06 in order; busy status (0) causes repeated polling with no write.
- RX:
  - Stimulus: drive serial 8'hA3 into uart_rx.
  - Required: on uart_irq, a read at 32'h80000004; rx_data=8'hA3 with a one-cycle rx_valid; uart_irq_response pulses once; uart_irq clears.
- Priority:
  - Stimulus: uart_irq rises while the FIFO holds bytes and the UART is busy.
  - Required: the next IDLE arbitration issues the BASE+4 read before any further BASE+0 poll; the TX stream still completes intact.
- Reset mid-write:
  - Stimulus: assert reset asynchronously while in WRITE_WAIT with 3 bytes queued.
  - Required: outputs reach their reset values immediately without waiting for a clock edge; FIFO is empty; no further requests after release until a new push.
- Responder stall:
  - Stimulus: delay read_response and write_response by 5 cycles.
  - Required: rw_address and write_data stay stable throughout; exactly one request pulse per transaction.
